// File: rtl/aes128_cbc_decrypt_ctrl.sv
// CBC chaining controller for the AES-128 inverse cipher core: issues one decipher run
// per accepted ciphertext block and XORs the result with the chaining value.
module aes128_cbc_decrypt_ctrl #(
    parameter int unsigned BYPASS_XOR  = 0,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [127:0]     iv_in,
    input  logic             iv_load,
    input  logic [127:0]     ct_data,
    input  logic             ct_last,
    input  logic             ct_valid,
    output logic             ct_ready,
    output logic [127:0]     cipher_text,
    output logic             decipher_en,
    input  logic [127:0]     plain_text,
    input  logic             decipher_ready,
    output logic [127:0]     pt_data,
    output logic             pt_last,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err_timeout
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               rdy_q, rdy_d;
    logic [BLK_W-1:0]   ct_q, ct_d;
    logic               last_q, last_d;
    logic               en_q, en_d;
    logic [BLK_W-1:0]   iv_q, iv_d;
    logic [BLK_W-1:0]   chain_q, chain_d;
    logic [BLK_W-1:0]   pt_q, pt_d;
    logic               pt_last_q, pt_last_d;
    logic               pt_vld_q, pt_vld_d;
    logic [CNT_W-1:0]   blk_q, blk_d;
    logic               err_q, err_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;

    // rdy_q is low in reset and the first cycle after; iv_load masks acceptance
    assign ct_ready    = rdy_q && !iv_load;
    assign cipher_text = ct_q;
    assign decipher_en = en_q;
    assign pt_data     = pt_q;
    assign pt_last     = pt_last_q;
    assign pt_valid    = pt_vld_q;
    assign blk_cnt     = blk_q;
    assign err_timeout = err_q;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        ct_d      = ct_q;
        last_d    = last_q;
        iv_d      = iv_q;
        chain_d   = chain_q;
        pt_d      = pt_q;
        pt_last_d = pt_last_q;
        blk_d     = blk_q;
        err_d     = err_q;
        wcnt_d    = wcnt_q;

        case (state_q)
            S_IDLE: begin
                if (iv_load) begin
                    iv_d    = iv_in;
                    chain_d = iv_in;
                    blk_d   = '0;
                    err_d   = 1'b0;
                end else if (ct_valid && rdy_q) begin
                    ct_d    = ct_data;
                    last_d  = ct_last;
                    state_d = S_START;
                end
            end
            S_START: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (decipher_ready) begin
                    pt_last_d = last_q;
                    state_d   = S_OUT;
                    if (BYPASS_XOR != 0) begin
                        pt_d = plain_text;
                    end else begin
                        pt_d    = plain_text ^ chain_q;
                        chain_d = last_q ? iv_q : ct_q;
                    end
                end else if (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
                    // core never answered: drop the block, keep the chain
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (pt_ready) begin
                    blk_d   = blk_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rdy_d    = (state_d == S_IDLE);
        en_d     = (state_d == S_START);
        pt_vld_d = (state_d == S_OUT);
    end

    // State and data registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b0;
            ct_q      <= '0;
            last_q    <= 1'b0;
            en_q      <= 1'b0;
            iv_q      <= '0;
            chain_q   <= '0;
            pt_q      <= '0;
            pt_last_q <= 1'b0;
            pt_vld_q  <= 1'b0;
            blk_q     <= '0;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            ct_q      <= ct_d;
            last_q    <= last_d;
            en_q      <= en_d;
            iv_q      <= iv_d;
            chain_q   <= chain_d;
            pt_q      <= pt_d;
            pt_last_q <= pt_last_d;
            pt_vld_q  <= pt_vld_d;
            blk_q     <= blk_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_aes128_cbc_decrypt_ctrl.sv
// Scoreboard bench: CBC instance (0) and ECB-bypass instance (1), each with an
// inverse-cipher stub that answers from a table of SP800-38A raw decrypt results.
module tb_aes128_cbc_decrypt_ctrl;

    localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    // raw inverse-cipher outputs: D(C1) = P1 ^ IV, D(C2) = P2 ^ C1
    localparam logic [127:0] D1 = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] D2 = 128'hd86421fb9f1a1eda505ee1375746972c;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic         clk_sys;
    logic         rst;
    logic [127:0] iv_in     [2];
    logic         iv_load   [2];
    logic [127:0] ct_data   [2];
    logic         ct_last   [2];
    logic         ct_valid  [2];
    logic         ct_ready  [2];
    logic [127:0] cipher_tx [2];
    logic         dec_en    [2];
    logic [127:0] pt_data   [2];
    logic         pt_last   [2];
    logic         pt_valid  [2];
    logic         pt_ready  [2];
    logic [31:0]  blk_cnt   [2];
    logic         err_to    [2];
    bit           mute      [2];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [127:0] core_model(input logic [127:0] c);
        if (c == C1) return D1;
        if (c == C2) return D2;
        return ~c;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic         dec_rdy;
        logic [127:0] raw;
        int           en_cnt;
        exp_t         sb_q[$];

        aes128_cbc_decrypt_ctrl #(
            .BYPASS_XOR (g),
            .TIMEOUT_CYC(64),
            .CNT_W      (32)
        ) u_dut (
            .clk_sys       (clk_sys),
            .rst           (rst),
            .iv_in         (iv_in[g]),
            .iv_load       (iv_load[g]),
            .ct_data       (ct_data[g]),
            .ct_last       (ct_last[g]),
            .ct_valid      (ct_valid[g]),
            .ct_ready      (ct_ready[g]),
            .cipher_text   (cipher_tx[g]),
            .decipher_en   (dec_en[g]),
            .plain_text    (raw),
            .decipher_ready(dec_rdy),
            .pt_data       (pt_data[g]),
            .pt_last       (pt_last[g]),
            .pt_valid      (pt_valid[g]),
            .pt_ready      (pt_ready[g]),
            .blk_cnt       (blk_cnt[g]),
            .err_timeout   (err_to[g])
        );

        // core stub: answers a few cycles after each start pulse unless muted
        initial begin
            bit busy;
            int cnt;
            dec_rdy = 1'b0;
            raw     = '0;
            en_cnt  = 0;
            busy    = 1'b0;
            cnt     = 0;
            forever begin
                @(negedge clk_sys);
                dec_rdy = 1'b0;
                if (rst) begin
                    busy = 1'b0;
                end else if (busy) begin
                    if (cnt == 0) begin
                        dec_rdy = 1'b1;
                        raw     = core_model(cipher_tx[g]);
                        busy    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (dec_en[g]) begin
                    en_cnt++;
                    if (!mute[g]) begin
                        busy = 1'b1;
                        cnt  = 3;
                    end
                end
            end
        end

        // monitor: compare every delivered plaintext against the scoreboard
        always @(negedge clk_sys) begin
            if (!rst && pt_valid[g] && pt_ready[g]) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut%0d.unexpected_pt: got %h expected none", g, pt_data[g]);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("dut%0d.pt_data", g), pt_data[g], e.data);
                    check($sformatf("dut%0d.pt_last", g), 128'(pt_last[g]), 128'(e.last));
                end
            end
        end
    end

    function automatic int sb_size(input int sel);
        return (sel == 0) ? g_dut[0].sb_q.size() : g_dut[1].sb_q.size();
    endfunction

    task automatic send(input int sel, input logic [127:0] ct, input logic last,
                        input logic [127:0] exp_pt, input bit push);
        exp_t e;
        bit   ok;
        e.data = exp_pt;
        e.last = last;
        if (push) begin
            if (sel == 0) g_dut[0].sb_q.push_back(e);
            else          g_dut[1].sb_q.push_back(e);
        end
        ct_data[sel]  = ct;
        ct_last[sel]  = last;
        ct_valid[sel] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (ct_ready[sel]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        check("accept", 128'(ok), 128'd1);
        @(negedge clk_sys);
        ct_valid[sel] = 1'b0;
    endtask

    task automatic wait_drain(input int sel);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (sb_size(sel) == 0 && !pt_valid[sel]) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", 128'(done), 128'd1);
    endtask

    task automatic pulse_iv(input int sel, input logic [127:0] v);
        @(negedge clk_sys);
        iv_in[sel]   = v;
        iv_load[sel] = 1'b1;
        @(negedge clk_sys);
        iv_load[sel] = 1'b0;
    endtask

    initial begin
        logic [127:0] held;
        bit           stable, rdy_low, got;
        int           e0;

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            iv_in[s] = '0;  iv_load[s] = 1'b0;  ct_data[s] = '0;  ct_last[s] = 1'b0;
            ct_valid[s] = 1'b0;  pt_ready[s] = 1'b1;  mute[s] = 1'b0;
        end
        repeat (3) @(negedge clk_sys);
        check("rst.ct_ready",    128'(ct_ready[0]), 128'd0);
        check("rst.decipher_en", 128'(dec_en[0]),   128'd0);
        check("rst.pt_valid",    128'(pt_valid[0]), 128'd0);
        check("rst.pt_data",     pt_data[0],        128'd0);
        check("rst.cipher_text", cipher_tx[0],      128'd0);
        check("rst.blk_cnt",     128'(blk_cnt[0]),  128'd0);
        check("rst.err_timeout", 128'(err_to[0]),   128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_sys);

        // IV load and ct_valid together: IV wins, block taken the next cycle
        iv_in[0] = IV;  iv_load[0] = 1'b1;
        ct_data[0] = C1;  ct_last[0] = 1'b0;  ct_valid[0] = 1'b1;
        #1;
        check("iv_wins.ct_ready", 128'(ct_ready[0]), 128'd0);
        @(negedge clk_sys);
        iv_load[0] = 1'b0;
        send(0, C1, 1'b0, P1, 1'b1);
        send(0, C2, 1'b1, P2, 1'b1);
        wait_drain(0);
        check("blk_cnt_after_2", 128'(blk_cnt[0]), 128'd2);
        // chain went back to IV after the last block
        send(0, C1, 1'b0, P1, 1'b1);
        wait_drain(0);
        check("blk_cnt_after_3", 128'(blk_cnt[0]), 128'd3);

        // downstream back-pressure
        pt_ready[0] = 1'b0;
        e0 = g_dut[0].en_cnt;
        send(0, C2, 1'b1, P2, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (pt_valid[0]) begin got = 1'b1; break; end
        end
        check("hold.pt_valid_seen", 128'(got), 128'd1);
        held = pt_data[0];
        stable = 1'b1;  rdy_low = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (!pt_valid[0] || pt_data[0] !== held) stable = 1'b0;
            if (ct_ready[0]) rdy_low = 1'b0;
        end
        check("hold.pt_stable",   128'(stable), 128'd1);
        check("hold.ct_ready_0",  128'(rdy_low), 128'd1);
        check("hold.single_en",   128'(g_dut[0].en_cnt - e0), 128'd1);
        pt_ready[0] = 1'b1;
        wait_drain(0);
        check("blk_cnt_after_4", 128'(blk_cnt[0]), 128'd4);

        // silent core: timeout after exactly 64 WAIT cycles
        mute[0] = 1'b1;
        send(0, C1, 1'b0, '0, 1'b0);
        check("to.start_pulse", 128'(dec_en[0]), 128'd1);
        repeat (64) @(negedge clk_sys);
        check("to.err_before",  128'(err_to[0]),   128'd0);
        @(negedge clk_sys);
        check("to.err_at_64",   128'(err_to[0]),   128'd1);
        check("to.idle_ready",  128'(ct_ready[0]), 128'd1);
        check("to.blk_cnt",     128'(blk_cnt[0]),  128'd4);
        mute[0] = 1'b0;
        send(0, C1, 1'b1, P1, 1'b1);
        wait_drain(0);
        check("to.err_sticky",  128'(err_to[0]),   128'd1);
        pulse_iv(0, IV);
        check("iv.err_clear",   128'(err_to[0]),   128'd0);
        check("iv.blk_clear",   128'(blk_cnt[0]),  128'd0);
        send(0, C1, 1'b0, P1, 1'b1);
        wait_drain(0);

        // reset while waiting on the core
        mute[0] = 1'b1;
        send(0, C2, 1'b0, '0, 1'b0);
        repeat (5) @(negedge clk_sys);
        rst = 1'b1;
        #1;
        check("mid_rst.decipher_en", 128'(dec_en[0]),   128'd0);
        check("mid_rst.pt_valid",    128'(pt_valid[0]), 128'd0);
        check("mid_rst.ct_ready",    128'(ct_ready[0]), 128'd0);
        check("mid_rst.cipher_text", cipher_tx[0],      128'd0);
        check("mid_rst.blk_cnt",     128'(blk_cnt[0]),  128'd0);
        @(negedge clk_sys);
        rst = 1'b0;
        mute[0] = 1'b0;
        repeat (2) @(negedge clk_sys);
        send(0, C1, 1'b0, D1, 1'b1);
        wait_drain(0);

        // ECB bypass instance; iv_load mid-WAIT must not clear blk_cnt
        pulse_iv(1, IV);
        send(1, C1, 1'b0, D1, 1'b1);
        wait_drain(1);
        check("byp.blk_cnt_1", 128'(blk_cnt[1]), 128'd1);
        send(1, C2, 1'b1, D2, 1'b1);
        @(negedge clk_sys);
        iv_in[1] = 128'hffff;
        iv_load[1] = 1'b1;
        @(negedge clk_sys);
        iv_load[1] = 1'b0;
        wait_drain(1);
        check("byp.blk_cnt_2", 128'(blk_cnt[1]), 128'd2);

        repeat (3) @(negedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
